// File: rtl/forward_scoreboard.sv
// Scoreboard-based forwarding and hazard unit.
// Each architectural register carries two countdown counters: cycles until its pending result
// shows up on some result tap (cnt_fwd) and cycles until it is written back (cnt_wb). Decode
// source reads either fall through to the register file, forward from the youngest matching
// tap, or stall decode while the producer's result is not yet forwardable.
module forward_scoreboard #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned NRD   = 2,
  parameter int unsigned NTAP  = 6,
  parameter int unsigned LAT_W = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 issue_valid,
  output logic                 issue_ready,
  input  logic [4:0]           issue_rd,
  input  logic                 issue_wr_en,
  input  logic [LAT_W-1:0]     issue_fwd_lat,
  input  logic [LAT_W-1:0]     issue_wb_lat,
  input  logic [NRD*5-1:0]     rs_addr,
  output logic [NRD*XLEN-1:0]  fwd_data,
  output logic [NRD-1:0]       fwd_sel,
  output logic                 stall,
  input  logic [NTAP-1:0]      tap_valid,
  input  logic [NTAP*5-1:0]    tap_rd,
  input  logic [NTAP*XLEN-1:0] tap_data,
  input  logic                 flush,
  output logic                 fwd_err,
  output logic [31:0]          stall_cnt
);

  // Per-register countdowns; entry 0 is never loaded so x0 stays permanently idle.
  logic [LAT_W-1:0] cnt_fwd_q [32];
  logic [LAT_W-1:0] cnt_fwd_d [32];
  logic [LAT_W-1:0] cnt_wb_q  [32];
  logic [LAT_W-1:0] cnt_wb_d  [32];

  logic [31:0]      pending;
  logic [LAT_W-1:0] issue_lat_min;
  logic             issue_fire;
  logic             err_any;

  logic             fwd_err_q, fwd_err_d;
  logic [31:0]      stall_cnt_q, stall_cnt_d;

  // Pending means a write is still on its way to the register file.
  always_comb begin
    pending = '0;
    for (int r = 0; r < 32; r++) begin
      pending[r] = (r != 0) && (cnt_wb_q[r] != '0);
    end
  end

  // A result can never be forwardable later than it is written back.
  assign issue_lat_min = (issue_fwd_lat < issue_wb_lat) ? issue_fwd_lat : issue_wb_lat;

  // Refuse a younger write that would retire before an older in-flight write to the same rd.
  assign issue_ready = !(issue_wr_en && pending[issue_rd] &&
                         (cnt_wb_q[issue_rd] > issue_wb_lat));

  assign issue_fire = issue_valid && issue_ready && issue_wr_en &&
                      (issue_rd != 5'd0) && !flush;

  // Counter next-state: flush clears, an issue load beats the decrement, otherwise count down.
  always_comb begin
    for (int r = 0; r < 32; r++) begin
      cnt_fwd_d[r] = cnt_fwd_q[r];
      cnt_wb_d[r]  = cnt_wb_q[r];
      if (flush) begin
        cnt_fwd_d[r] = '0;
        cnt_wb_d[r]  = '0;
      end else if (issue_fire && (issue_rd == 5'(r))) begin
        cnt_fwd_d[r] = issue_lat_min;
        cnt_wb_d[r]  = issue_wb_lat;
      end else begin
        if (cnt_fwd_q[r] != '0) cnt_fwd_d[r] = cnt_fwd_q[r] - 1'b1;
        if (cnt_wb_q[r] != '0)  cnt_wb_d[r]  = cnt_wb_q[r] - 1'b1;
      end
    end
  end

  // Per-port operand resolution from pre-issue state; lowest-index tap is the youngest result.
  always_comb begin
    logic [4:0] rs;
    logic       found;
    fwd_data = '0;
    fwd_sel  = '0;
    stall    = 1'b0;
    err_any  = 1'b0;
    rs       = '0;
    found    = 1'b0;
    for (int i = 0; i < NRD; i++) begin
      rs    = rs_addr[5*i +: 5];
      found = 1'b0;
      if (pending[rs]) begin
        fwd_sel[i] = 1'b1;
        if (cnt_fwd_q[rs] != '0) begin
          stall = 1'b1;
        end else begin
          for (int j = 0; j < NTAP; j++) begin
            if (!found && tap_valid[j] && (tap_rd[5*j +: 5] == rs)) begin
              found                   = 1'b1;
              fwd_data[XLEN*i +: XLEN] = tap_data[XLEN*j +: XLEN];
            end
          end
          // Forwardable by the scoreboard but absent from every tap: pipeline bookkeeping bug.
          if (!found) begin
            stall   = 1'b1;
            err_any = 1'b1;
          end
        end
      end
    end
  end

  // Sticky error flag and saturating stall counter survive flush.
  always_comb begin
    fwd_err_d   = fwd_err_q | err_any;
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  // State registers with synchronous active-low reset; reset takes precedence over flush.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_fwd_q   <= '{default: '0};
      cnt_wb_q    <= '{default: '0};
      fwd_err_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      cnt_fwd_q   <= cnt_fwd_d;
      cnt_wb_q    <= cnt_wb_d;
      fwd_err_q   <= fwd_err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign fwd_err   = fwd_err_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_forward_scoreboard.sv
// Self-checking bench for forward_scoreboard: directed sequences, a vector table and a
// randomized run against a timestamp-based reference model.
module tb_forward_scoreboard;

  localparam int unsigned XLEN  = 64;
  localparam int unsigned NRD   = 2;
  localparam int unsigned NTAP  = 6;
  localparam int unsigned LAT_W = 3;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 issue_valid;
  logic                 issue_ready;
  logic [4:0]           issue_rd;
  logic                 issue_wr_en;
  logic [LAT_W-1:0]     issue_fwd_lat;
  logic [LAT_W-1:0]     issue_wb_lat;
  logic [NRD*5-1:0]     rs_addr;
  logic [NRD*XLEN-1:0]  fwd_data;
  logic [NRD-1:0]       fwd_sel;
  logic                 stall;
  logic [NTAP-1:0]      tap_valid;
  logic [NTAP*5-1:0]    tap_rd;
  logic [NTAP*XLEN-1:0] tap_data;
  logic                 flush;
  logic                 fwd_err;
  logic [31:0]          stall_cnt;

  forward_scoreboard #(
    .XLEN (XLEN),
    .NRD  (NRD),
    .NTAP (NTAP),
    .LAT_W(LAT_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .issue_valid  (issue_valid),
    .issue_ready  (issue_ready),
    .issue_rd     (issue_rd),
    .issue_wr_en  (issue_wr_en),
    .issue_fwd_lat(issue_fwd_lat),
    .issue_wb_lat (issue_wb_lat),
    .rs_addr      (rs_addr),
    .fwd_data     (fwd_data),
    .fwd_sel      (fwd_sel),
    .stall        (stall),
    .tap_valid    (tap_valid),
    .tap_rd       (tap_rd),
    .tap_data     (tap_data),
    .flush        (flush),
    .fwd_err      (fwd_err),
    .stall_cnt    (stall_cnt)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_taps();
    tap_valid = '0;
    tap_rd    = '0;
    tap_data  = '0;
  endtask

  task automatic set_tap(input int idx, input logic [4:0] rd, input logic [63:0] d);
    tap_valid[idx]          = 1'b1;
    tap_rd[5*idx +: 5]       = rd;
    tap_data[XLEN*idx +: XLEN] = d;
  endtask

  task automatic issue_op(input logic [4:0] rd, input logic [2:0] fl, input logic [2:0] wl);
    issue_valid   = 1'b1;
    issue_wr_en   = 1'b1;
    issue_rd      = rd;
    issue_fwd_lat = fl;
    issue_wb_lat  = wl;
    tick();
    issue_valid = 1'b0;
    issue_wr_en = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  // Vector table: issue one producer, wait, then read it on port 0 with given taps.
  typedef struct {
    logic [4:0]           rd;
    logic [2:0]           fl;
    logic [2:0]           wl;
    int                   wt;
    logic [4:0]           rs0;
    logic [NTAP-1:0]      tv;
    logic [NTAP*5-1:0]    trd;
    logic [NTAP*XLEN-1:0] tdat;
    logic                 esel;
    logic [63:0]          edata;
    logic                 estall;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic [4:0] rd, input logic [2:0] fl, input logic [2:0] wl,
                              input int wt, input logic [4:0] rs0, input logic esel,
                              input logic [63:0] edata, input logic estall);
    vec_t v;
    v.rd = rd; v.fl = fl; v.wl = wl; v.wt = wt; v.rs0 = rs0;
    v.tv = '0; v.trd = '0; v.tdat = '0;
    v.esel = esel; v.edata = edata; v.estall = estall;
    return v;
  endfunction

  task automatic vtap(input int k, input int idx, input logic [4:0] rd, input logic [63:0] d);
    vecs[k].tv[idx]             = 1'b1;
    vecs[k].trd[5*idx +: 5]       = rd;
    vecs[k].tdat[XLEN*idx +: XLEN] = d;
  endtask

  // Reference model: absolute cycle at which each register becomes forwardable / written back.
  int m_fwd_at [32];
  int m_wb_at  [32];
  int now;
  int m_stall_cnt;
  logic m_fwd_err;

  task automatic model_clear();
    for (int r = 0; r < 32; r++) begin
      m_fwd_at[r] = 0;
      m_wb_at[r]  = 0;
    end
  endtask

  initial begin
    rst_n = 1'b0; issue_valid = 1'b0; issue_rd = '0; issue_wr_en = 1'b0;
    issue_fwd_lat = '0; issue_wb_lat = '0; rs_addr = '0; flush = 1'b0;
    clear_taps();

    // Reset state
    rs_addr = {5'd5, 5'd3};
    tick(); tick();
    chk("reset fwd_sel", 64'(fwd_sel), 64'd0);
    chk("reset fwd_data", fwd_data[63:0], 64'd0);
    chk("reset stall", 64'(stall), 64'd0);
    chk("reset issue_ready", 64'(issue_ready), 64'd1);
    chk("reset stall_cnt", 64'(stall_cnt), 64'd0);
    chk("reset fwd_err", 64'(fwd_err), 64'd0);
    rst_n = 1'b1;

    // Producer x5 fwd 2 wb 4: two stall cycles, then forwarded, then retired
    rs_addr = {5'd0, 5'd5};
    issue_op(5'd5, 3'd2, 3'd4);
    chk("x5 stall c1", 64'(stall), 64'd1);
    tick();
    chk("x5 stall c2", 64'(stall), 64'd1);
    set_tap(2, 5'd5, 64'hDEAD);
    tick();
    chk("x5 c3 stall", 64'(stall), 64'd0);
    chk("x5 c3 sel", 64'(fwd_sel), 64'd1);
    chk("x5 c3 data", fwd_data[63:0], 64'hDEAD);
    chk("x5 stall_cnt", 64'(stall_cnt), 64'd2);
    tick(); tick();
    chk("x5 c5 sel", 64'(fwd_sel), 64'd0);
    clear_taps();

    // WAW ordering on x9
    issue_op(5'd9, 3'd1, 3'd5);
    issue_valid = 1'b1; issue_wr_en = 1'b1; issue_rd = 5'd9;
    issue_fwd_lat = 3'd1; issue_wb_lat = 3'd2;
    #1 chk("waw short blocked", 64'(issue_ready), 64'd0);
    issue_fwd_lat = 3'd6; issue_wb_lat = 3'd6;
    #1 chk("waw long accepted", 64'(issue_ready), 64'd1);
    tick();
    issue_valid = 1'b0; issue_wr_en = 1'b0;
    rs_addr = {5'd0, 5'd9};
    repeat (5) tick();
    chk("waw reload pending", 64'(fwd_sel), 64'd1);
    tick();
    chk("waw reload retired", 64'(fwd_sel), 64'd0);

    // Counter at 1 with a new issue to the same rd: the issue value loads
    issue_op(5'd10, 3'd1, 3'd1);
    issue_valid = 1'b1; issue_wr_en = 1'b1; issue_rd = 5'd10;
    issue_fwd_lat = 3'd3; issue_wb_lat = 3'd3;
    #1 chk("reload ready", 64'(issue_ready), 64'd1);
    tick();
    issue_valid = 1'b0; issue_wr_en = 1'b0;
    rs_addr = {5'd0, 5'd10};
    #1 chk("reload stall", 64'(stall), 64'd1);
    do_flush();

    // Issue in a flush cycle is dropped
    issue_valid = 1'b1; issue_wr_en = 1'b1; issue_rd = 5'd11;
    issue_fwd_lat = 3'd2; issue_wb_lat = 3'd4; flush = 1'b1;
    tick();
    issue_valid = 1'b0; issue_wr_en = 1'b0; flush = 1'b0;
    rs_addr = {5'd0, 5'd11};
    #1 chk("flush drops issue", 64'({fwd_sel, stall}), 64'd0);

    // Flush clears x5 and x6
    rs_addr = {5'd6, 5'd5};
    issue_op(5'd5, 3'd2, 3'd4);
    issue_op(5'd6, 3'd3, 3'd5);
    chk("pre-flush sel", 64'(fwd_sel), 64'd3);
    do_flush();
    chk("post-flush sel", 64'(fwd_sel), 64'd0);
    chk("post-flush stall", 64'(stall), 64'd0);
    rs_addr = '0;
    issue_op(5'd0, 3'd3, 3'd5);
    chk("x0 no stall", 64'({fwd_sel, stall}), 64'd0);

    // Forwardable register with no tap: stall, sticky fwd_err across flush
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    rs_addr = {5'd0, 5'd3};
    issue_op(5'd3, 3'd1, 3'd3);
    tick();
    chk("no tap stall", 64'(stall), 64'd1);
    chk("fwd_err not yet", 64'(fwd_err), 64'd0);
    tick();
    chk("fwd_err set", 64'(fwd_err), 64'd1);
    do_flush();
    chk("fwd_err after flush", 64'(fwd_err), 64'd1);

    // Reset beats flush
    rst_n = 1'b0; flush = 1'b1;
    tick();
    rst_n = 1'b1; flush = 1'b0;
    chk("rst over flush stall_cnt", 64'(stall_cnt), 64'd0);
    chk("rst over flush fwd_err", 64'(fwd_err), 64'd0);

    // Vector table
    vecs[0]  = mk(5'd5, 3'd2, 3'd4, 0, 5'd5, 1'b1, 64'h0, 1'b1);
    vecs[1]  = mk(5'd5, 3'd2, 3'd4, 1, 5'd5, 1'b1, 64'h0, 1'b1);
    vecs[2]  = mk(5'd5, 3'd2, 3'd4, 2, 5'd5, 1'b1, 64'hDEAD, 1'b0);
    vtap(2, 2, 5'd5, 64'hDEAD);
    vecs[3]  = mk(5'd5, 3'd2, 3'd4, 3, 5'd5, 1'b1, 64'hDEAD, 1'b0);
    vtap(3, 2, 5'd5, 64'hDEAD);
    vecs[4]  = mk(5'd5, 3'd2, 3'd4, 4, 5'd5, 1'b0, 64'h0, 1'b0);
    vtap(4, 2, 5'd5, 64'hDEAD);
    vecs[5]  = mk(5'd7, 3'd1, 3'd3, 1, 5'd7, 1'b1, 64'h11, 1'b0);
    vtap(5, 1, 5'd7, 64'h11); vtap(5, 4, 5'd7, 64'h44);
    vecs[6]  = mk(5'd7, 3'd1, 3'd3, 1, 5'd7, 1'b1, 64'h44, 1'b0);
    vtap(6, 0, 5'd8, 64'h99); vtap(6, 4, 5'd7, 64'h44);
    vecs[7]  = mk(5'd3, 3'd1, 3'd3, 1, 5'd3, 1'b1, 64'h0, 1'b1);
    vecs[8]  = mk(5'd0, 3'd3, 3'd5, 0, 5'd0, 1'b0, 64'h0, 1'b0);
    vecs[9]  = mk(5'd6, 3'd5, 3'd2, 1, 5'd6, 1'b1, 64'h0, 1'b1);
    vecs[10] = mk(5'd6, 3'd5, 3'd2, 2, 5'd6, 1'b0, 64'h0, 1'b0);
    vecs[11] = mk(5'd12, 3'd0, 3'd2, 0, 5'd12, 1'b1, 64'h1234, 1'b0);
    vtap(11, 5, 5'd12, 64'h1234);
    vecs[12] = mk(5'd4, 3'd3, 3'd0, 0, 5'd4, 1'b0, 64'h0, 1'b0);

    for (int k = 0; k < NV; k++) begin
      rs_addr = '0;
      clear_taps();
      do_flush();
      issue_op(vecs[k].rd, vecs[k].fl, vecs[k].wl);
      repeat (vecs[k].wt) tick();
      rs_addr   = {5'd0, vecs[k].rs0};
      tap_valid = vecs[k].tv;
      tap_rd    = vecs[k].trd;
      tap_data  = vecs[k].tdat;
      #1;
      chk($sformatf("vec%0d sel", k), 64'(fwd_sel), 64'(vecs[k].esel));
      chk($sformatf("vec%0d data", k), fwd_data[63:0], vecs[k].edata);
      chk($sformatf("vec%0d stall", k), 64'(stall), 64'(vecs[k].estall));
    end
    rs_addr = '0;
    clear_taps();

    // Randomized run against the timestamp model
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    model_clear();
    now = 0; m_stall_cnt = 0; m_fwd_err = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      logic       e_ready, e_stall, err_now, esel, hit;
      logic [4:0] r;
      logic [63:0] edat;
      int         ml;
      issue_valid   = 1'($urandom_range(0, 1));
      issue_wr_en   = 1'($urandom_range(0, 3) != 0);
      issue_rd      = 5'($urandom_range(0, 7));
      issue_fwd_lat = 3'($urandom_range(0, 7));
      issue_wb_lat  = 3'($urandom_range(0, 7));
      flush         = ($urandom_range(0, 15) == 0);
      for (int i = 0; i < NRD; i++) rs_addr[5*i +: 5] = 5'($urandom_range(0, 7));
      for (int j = 0; j < NTAP; j++) begin
        tap_valid[j]             = 1'($urandom_range(0, 1));
        tap_rd[5*j +: 5]          = 5'($urandom_range(0, 7));
        tap_data[XLEN*j +: XLEN]  = {$urandom, $urandom};
      end
      #1;
      e_ready = 1'b1;
      if (issue_wr_en && issue_rd != 0 && now < m_wb_at[issue_rd] &&
          (m_wb_at[issue_rd] - now) > int'(issue_wb_lat)) e_ready = 1'b0;
      chk("rnd issue_ready", 64'(issue_ready), 64'(e_ready));
      e_stall = 1'b0;
      err_now = 1'b0;
      for (int i = 0; i < NRD; i++) begin
        r    = rs_addr[5*i +: 5];
        esel = 1'b0;
        edat = '0;
        if (r != 0 && now < m_wb_at[r]) begin
          esel = 1'b1;
          if (now < m_fwd_at[r]) begin
            e_stall = 1'b1;
          end else begin
            hit = 1'b0;
            for (int j = 0; j < NTAP; j++) begin
              if (!hit && tap_valid[j] && tap_rd[5*j +: 5] == r) begin
                hit  = 1'b1;
                edat = tap_data[XLEN*j +: XLEN];
              end
            end
            if (!hit) begin
              e_stall = 1'b1;
              err_now = 1'b1;
            end
          end
        end
        chk($sformatf("rnd sel p%0d", i), 64'(fwd_sel[i]), 64'(esel));
        chk($sformatf("rnd data p%0d", i), fwd_data[XLEN*i +: XLEN], edat);
      end
      chk("rnd stall", 64'(stall), 64'(e_stall));
      if (e_stall) m_stall_cnt++;
      if (err_now) m_fwd_err = 1'b1;
      if (flush) begin
        model_clear();
      end else if (issue_valid && e_ready && issue_wr_en && issue_rd != 0) begin
        ml = (issue_fwd_lat < issue_wb_lat) ? int'(issue_fwd_lat) : int'(issue_wb_lat);
        m_wb_at[issue_rd]  = now + 1 + int'(issue_wb_lat);
        m_fwd_at[issue_rd] = now + 1 + ml;
      end
      tick();
      now++;
      chk("rnd stall_cnt", 64'(stall_cnt), 64'(m_stall_cnt));
      chk("rnd fwd_err", 64'(fwd_err), 64'(m_fwd_err));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/forward_scoreboard.md
# forward_scoreboard

Parametrised scoreboard-based forwarding and hazard unit for the deep RVCPU pipeline. It tracks every in-flight register write with per-register countdown counters. For each decode-stage source operand it selects the youngest forwardable result from a generic array of pipeline result taps. It stalls decode when a producer's result is not yet forwardable. A single generic tap array and per-instruction latencies replace the hard-wired per-stage priority chain.

## Interface
- XLEN, 64, data width
- NRD, 2, number of source read ports checked per cycle
- NTAP, 6, number of result taps; tap 0 is youngest, tap NTAP-1 oldest
- LAT_W, 3, width of latency counters (max latency 2^LAT_W-1)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- issue_valid  in  1  decode issues an instruction this cycle
- issue_ready  out  1  scoreboard accepts the issue
- issue_rd  in  5  destination register
- issue_wr_en  in  1  instruction writes a register
- issue_fwd_lat  in  LAT_W  cycles from issue until the result is visible on some tap
- issue_wb_lat  in  LAT_W  cycles from issue until the register file is written
- rs_addr  in  NRD*5  source addresses, port i at [5i+4:5i]
- fwd_data  out  NRD*XLEN  forwarded operand per port
- fwd_sel  out  NRD  1 = use fwd_data; 0 = use register file
- stall  out  1  hold decode; OR over ports of the not-ready condition
- tap_valid  in  NTAP  tap carries a register-writing result
- tap_rd  in  NTAP*5  tap destination
- tap_data  in  NTAP*XLEN  tap result
- flush  in  1  pipeline redirect; clears all tracking state
- fwd_err  out  1  sticky: a forwardable register had no matching tap
- stall_cnt  out  32  count of cycles with stall=1

## Operation
- Each of registers 1..31 has cnt_fwd and cnt_wb (LAT_W bits each). The register is pending when cnt_wb != 0. x0 is never pending.
- Every cycle, each nonzero counter decrements by 1.
- Issue fires when issue_valid & issue_ready & issue_wr_en & issue_rd != 0. On fire:
  - cnt_fwd[rd] <= min(issue_fwd_lat, issue_wb_lat).
  - cnt_wb[rd] <= issue_wb_lat.
  - The load overrides the decrement in the same cycle.
- issue_wb_lat = 0 means no tracking.
- WAW ordering: issue_ready = 0 when issue_wr_en and issue_rd is pending with cnt_wb[rd] > issue_wb_lat. This prevents an older write from committing after a younger one. Otherwise issue_ready = 1.
- Per read port i, rs = rs_addr[i], evaluated in priority order:
  - rs = 0 or not pending: fwd_sel = 0, fwd_data = 0, no stall.
  - pending, cnt_fwd != 0: fwd_sel = 1, fwd_data = 0, not-ready (stall).
  - pending, cnt_fwd = 0: lowest-index tap j with tap_valid[j] & tap_rd[j] = rs supplies the data; fwd_sel = 1.
  - pending, cnt_fwd = 0, no tap matches: stall, and fwd_err is set on the next edge.
- Port reads use the registered state from before this cycle's issue update. An instruction never hazards on its own rd.
- flush: all counters are cleared on the next edge. Issue in the same cycle is ignored. fwd_err and stall_cnt are retained.
- stall_cnt increments while stall = 1 and saturates at 2^32-1.

## Timing
- Reset (rst_n low at an edge):
  - All counters clear; fwd_err and stall_cnt are 0.
  - Outputs then read fwd_sel = 0, fwd_data = 0, stall = 0, issue_ready = 1.
- fwd_data, fwd_sel, stall and issue_ready are combinational from registered state, rs_addr and the taps. There are no registered outputs except fwd_err and stall_cnt.
- A producer issued at edge T with fwd_lat F is stalled upon for consumer reads in cycles T..T+F-1. It is forwardable from cycle T+F, and no longer pending from cycle T+W.
- Simultaneous flush and rst_n low: reset wins.
- Counter at 1 together with issue to the same rd: the issue value loads.

## Test plan
- Reset with rs_addr = {5,3}: fwd_sel = 00, stall = 0, issue_ready = 1, stall_cnt = 0.
- Issue rd = 5, fwd_lat = 2, wb_lat = 4; port 0 reads x5:
  - stall = 1 for 2 cycles, stall_cnt = 2.
  - Cycle 3: tap 2 = {x5, 0xDEAD} → fwd_data = 0xDEAD, fwd_sel = 1.
  - Cycle 5: fwd_sel = 0.
- Taps 1 and 4 both carry x7 (0x11 vs 0x44) with x7 forwardable → fwd_data = 0x11.
- WAW check:
  - x9 pending with cnt_wb = 5; issue rd = 9 with wb_lat = 2 → issue_ready = 0.
  - Same issue with wb_lat = 6 → accepted; counters load 6.
- x3 forwardable with no matching tap → stall = 1, fwd_err = 1 next cycle and stays 1 after flush.
- flush with x5 and x6 pending → next cycle, reads of both give fwd_sel = 0, stall = 0. Issue to x0 never stalls.
